// File: rtl/lut_cfg_loader.sv
// Streams bitstream words into per-LUT configuration frames and commits each
// frame to a chain of fracturable LUTs through a one-hot config enable.
module lut_cfg_loader #(
  parameter int unsigned INPUTS   = 4,
  parameter int unsigned NUM_LUTS = 8,
  parameter int unsigned WORD_W   = 8
) (
  input  logic                                             cclk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic                                             abort,
  input  logic [WORD_W-1:0]                                word_in,
  input  logic                                             word_valid,
  output logic                                             word_ready,
  output logic [2*(2**INPUTS):0]                           config_out,
  output logic [NUM_LUTS-1:0]                              cen_out,
  output logic [((NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1)-1:0] lut_idx,
  output logic                                             busy,
  output logic                                             done
);

  localparam int unsigned CFG_W  = 2 * (2 ** INPUTS) + 1;
  localparam int unsigned NWORDS = (CFG_W + WORD_W - 1) / WORD_W;
  localparam int unsigned PAD_W  = NWORDS * WORD_W;
  localparam int unsigned IDX_W  = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam int unsigned WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [WCNT_W-1:0] r_wcnt;
  logic [PAD_W-1:0]  r_frame;
  logic [PAD_W-1:0]  w_frame_nxt;
  logic [CFG_W-1:0]  r_config;
  logic              w_accept;
  logic              w_last_word;
  logic              w_last_lut;
  logic              w_load_start;
  logic              w_to_idle;

  assign w_last_word  = (r_wcnt == WCNT_W'(NWORDS - 1));
  assign w_last_lut   = (r_idx == IDX_W'(NUM_LUTS - 1));
  assign w_accept     = word_ready && word_valid;
  assign w_load_start = (r_state == S_IDLE) && start && !abort;
  assign w_to_idle    = (r_state != S_IDLE) && (abort || (r_state == S_DONE));

  assign config_out = r_config;
  assign lut_idx    = r_idx;

  // Slot the incoming word into its frame position; padding above CFG_W is dropped at commit.
  always_comb begin
    w_frame_nxt = r_frame;
    for (int k = 0; k < int'(NWORDS); k++) begin
      if (r_wcnt == WCNT_W'(k)) begin
        w_frame_nxt[k*WORD_W +: WORD_W] = word_in;
      end
    end
  end

  // Next state and state-decoded outputs; abort suppresses any pulse in its own cycle.
  always_comb begin
    w_state_nxt = r_state;
    word_ready  = 1'b0;
    cen_out     = '0;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !abort) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        word_ready = !abort;
        if (abort)                          w_state_nxt = S_IDLE;
        else if (word_valid && w_last_word) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          cen_out     = NUM_LUTS'(1) << r_idx;
          w_state_nxt = w_last_lut ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        done        = !abort;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_wcnt   <= '0;
      r_frame  <= '0;
      r_config <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_start || w_to_idle) begin
        r_idx   <= '0;
        r_wcnt  <= '0;
        r_frame <= '0;
      end else if (w_accept) begin
        if (w_last_word) begin
          r_wcnt   <= '0;
          r_frame  <= '0;
          r_config <= w_frame_nxt[CFG_W-1:0];
        end else begin
          r_wcnt  <= r_wcnt + 1'b1;
          r_frame <= w_frame_nxt;
        end
      end else if ((r_state == S_COMMIT) && !w_last_lut) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule
